// File: rtl/mips_alu_pkg.sv
// Shared encodings for the bit-serial ALU: aluop codes and sequencer states.
package mips_alu_pkg;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/mips_alu_serial_slice.sv
// Combinational 1-bit ALU slice; set/v are only meaningful at the MSB position.
module mips_alu_serial_slice (
  input  logic       ai,
  input  logic       bi,
  input  logic       ci,
  input  logic       less,
  input  logic [2:0] aluop,
  output logic       r,
  output logic       cout,
  output logic       set,
  output logic       v
);

  logic bb, sum;

  assign bb   = bi ^ aluop[2];
  assign sum  = ai ^ bb ^ ci;
  assign cout = (ai & bb) | (ai & ci) | (bb & ci);
  assign v    = cout ^ ci;
  // Sign of the true difference, corrected for overflow, drives SLT.
  assign set  = sum ^ v;

  always_comb begin
    r = 1'b0;
    case (aluop[1:0])
      2'd0: r = ai & bb;
      2'd1: r = ai | bb;
      2'd2: r = sum;
      2'd3: r = less;
      default: r = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_alu_serial_ctrl.sv
// Bit-serial ALU sequencer: walks one slice over WIDTH cycles, LSB first,
// then publishes result/zero/overflow with a one-cycle done pulse.
module mips_alu_serial_ctrl
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, fin;
  logic [2:0]       op;
  logic [CNT_W-1:0] cnt;
  logic             carry, set_q, v_q;
  logic             r, cout, set, v;

  mips_alu_serial_slice u_slice (
    .ai    (a_sh[0]),
    .bi    (b_sh[0]),
    .ci    (carry),
    .less  (1'b0),
    .aluop (op),
    .r     (r),
    .cout  (cout),
    .set   (set),
    .v     (v)
  );

  // SLT shifts in zeros for every bit; bit 0 is back-filled from the MSB set.
  always_comb begin
    fin = res_sh;
    if (op[1:0] == 2'b11) fin[0] = set_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      res_sh   <= '0;
      op       <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      set_q    <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op    <= aluop;
            carry <= aluop[2];
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {r, res_sh[WIDTH-1:1]};
          carry  <= cout;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            set_q <= set;
            v_q   <= v;
            state <= FINISH;
          end
        end
        FINISH: begin
          result   <= fin;
          zero     <= (fin == '0);
          overflow <= v_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_alu_serial_ctrl.sv
// Scoreboard bench for the bit-serial ALU: directed ops push expectations,
// a negedge monitor pops and checks on every done pulse.
module tb_mips_alu_serial_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  aluop = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, zero, overflow;
  logic [31:0] result;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0, n_err = 0;
  int   busy_run = 0;

  mips_alu_serial_ctrl #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .aluop    (aluop),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst) busy_run = 0;
    else begin
      if (busy) busy_run++;
      if (done) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: done at cycle %0d with no op outstanding", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
          chk({e.name, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
          chk({e.name, "_latency"}, cyc, e.done_cyc);
          chk({e.name, "_busy_cycles"}, busy_run, LAT);
        end
        busy_run = 0;
      end
    end
  end

  // Call at/after a negedge; presents start for exactly one rising edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] er, input logic ez,
                       input logic eo, input bit track);
    exp_t e;
    aluop = op; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom; b = $urandom; aluop = 3'($urandom);
    if (track) begin
      e.name = name; e.res = er; e.zero = ez; e.ovf = eo; e.done_cyc = cyc + LAT;
      q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name, output int at);
    at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin at = cyc; return; end
    end
    n_cmp++;
    n_err++;
    $display("FAIL %s_timeout: no done within 200 cycles", name);
  endtask

  initial begin
    int t0, t1;
    #12;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    issue("add_ovf", 3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, 1);
    wait_done("add_ovf", t0);
    issue("sub_zero", 3'b110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
    wait_done("sub_zero", t0);
    issue("sub_ovf", 3'b110, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    wait_done("sub_ovf", t0);
    issue("slt_neg", 3'b111, 32'hFFFF_FFFD, 32'd2, 32'd1, 1'b0, 1'b0, 1);
    wait_done("slt_neg", t0);
    issue("slt_vcorr", 3'b111, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b1, 1);
    wait_done("slt_vcorr", t0);
    issue("slt_ge", 3'b111, 32'd7, 32'd3, 32'd0, 1'b1, 1'b0, 1);
    wait_done("slt_ge", t0);

    // AND then OR back-to-back: second start lands in the first done cycle.
    issue("and", 3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1);
    wait_done("and", t0);
    issue("or", 3'b001, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0, 1);
    wait_done("or", t1);
    chk("b2b_spacing", t1 - t0, WIDTH + 2);

    // Start pulsed while busy must be ignored.
    issue("add_busy", 3'b010, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1'b0, 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    aluop = 3'b001; a = 32'hDEAD_BEEF; b = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("add_busy", t0);
    repeat (3) @(negedge clk);
    chk("ignored_start_hold", result, 32'h2345_6789);

    // Async reset mid-operation: outputs clear immediately, no done.
    @(negedge clk);
    issue("abort", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 0);
    repeat (10) @(posedge clk);
    #2;
    a = $urandom; b = $urandom; aluop = 3'($urandom); start = 1'($urandom);
    rst = 1'b1;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_result", result, 32'd0);
    chk("arst_zero", {31'd0, zero}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    issue("add_after_rst", 3'b010, 32'd3, 32'd4, 32'd7, 1'b0, 1'b0, 1);
    wait_done("add_after_rst", t0);

    repeat (40) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
